// File: rtl/game_pkg.sv
// Shared types and constants for the Red-Light-Green-Light referee.
package game_pkg;

    typedef enum logic [1:0] {IDLE, RUN, OVER} ref_state_t;

    localparam int MAX_PLAYERS  = 8;
    localparam int PLAYER_IDX_W = 3;

    // Lowest set bit wins, so simultaneous finishers resolve to the smaller index.
    function automatic logic [PLAYER_IDX_W-1:0] lowest_set(input logic [MAX_PLAYERS-1:0] v);
        logic [PLAYER_IDX_W-1:0] idx;
        idx = '0;
        for (int i = MAX_PLAYERS - 1; i >= 0; i--) begin
            if (v[i]) idx = PLAYER_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/game_referee_sync2.sv
// Parameterized-width 2-flop synchronizer with synchronous active-high reset.
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/game_referee.sv
// Red-Light-Green-Light referee: eliminates movers during red, tracks finishers and the round timer.
// Optional grace window after red onset is enabled with `define REFEREE_GRACE_EN.
module game_referee
    import game_pkg::*;
#(
    parameter int          N_PLAYERS    = 4,
    parameter logic [31:0] GRACE_CYCLES = 32'd50_000_000,
    parameter logic [31:0] TIME_LIMIT   = 32'd3_000_000_000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    red,
    input  logic                    green,
    input  logic                    start,
    input  logic [N_PLAYERS-1:0]    move,
    input  logic [N_PLAYERS-1:0]    finish,
    output logic [N_PLAYERS-1:0]    alive,
    output logic [N_PLAYERS-1:0]    finished,
    output logic                    running,
    output logic                    game_over,
    output logic                    winner_valid,
    output logic [PLAYER_IDX_W-1:0] winner
);

    if (N_PLAYERS < 1 || N_PLAYERS > MAX_PLAYERS) begin : g_bad_cfg
        $error("game_referee: N_PLAYERS must be 1..8");
    end

    logic [1:0]           light_s;
    logic                 red_s;
    logic                 green_s;
    logic [N_PLAYERS-1:0] move_s;
    logic [N_PLAYERS-1:0] finish_s;

    sync2 #(.W(2)) u_sync_light (
        .clk (clk),
        .rst (rst),
        .d_i ({red, green}),
        .q_o (light_s)
    );

    sync2 #(.W(N_PLAYERS)) u_sync_move (
        .clk (clk),
        .rst (rst),
        .d_i (move),
        .q_o (move_s)
    );

    sync2 #(.W(N_PLAYERS)) u_sync_finish (
        .clk (clk),
        .rst (rst),
        .d_i (finish),
        .q_o (finish_s)
    );

    assign red_s   = light_s[1];
    assign green_s = light_s[0];

    // Only a clean green (green without red) counts as green; anything else is red.
    logic red_phase;
    assign red_phase = !(green_s && !red_s);

    ref_state_t              state_q, state_d;
    logic [31:0]             timer_q, timer_d;
    logic [N_PLAYERS-1:0]    alive_q, alive_d;
    logic [N_PLAYERS-1:0]    finished_q, finished_d;
    logic                    winner_valid_q, winner_valid_d;
    logic [PLAYER_IDX_W-1:0] winner_q, winner_d;
    logic                    running_q, game_over_q;

    logic round_start;
    logic elim_armed;
    assign round_start = start && (state_q != RUN);

`ifdef REFEREE_GRACE_EN
    logic [31:0] grace_q, grace_d;
    logic        red_phase_q;

    always_comb begin
        grace_d = grace_q;
        if (round_start || !red_phase) begin
            grace_d = '0;
        end else if (!red_phase_q) begin
            grace_d = GRACE_CYCLES;
        end else if (grace_q != '0) begin
            grace_d = grace_q - 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grace_q     <= '0;
            red_phase_q <= 1'b0;
        end else begin
            grace_q     <= grace_d;
            red_phase_q <= red_phase;
        end
    end

    // The rise cycle itself is still inside the window: the load only lands next cycle.
    assign elim_armed = red_phase && red_phase_q && (grace_q == '0);
`else
    assign elim_armed = red_phase;
`endif

    logic [N_PLAYERS-1:0] elim;
    logic [N_PLAYERS-1:0] fin_new;

    always_comb begin
        state_d        = state_q;
        timer_d        = timer_q;
        alive_d        = alive_q;
        finished_d     = finished_q;
        winner_valid_d = winner_valid_q;
        winner_d       = winner_q;
        elim           = '0;
        fin_new        = '0;
        case (state_q)
            IDLE, OVER: begin
                if (start) begin
                    state_d        = RUN;
                    timer_d        = '0;
                    alive_d        = '1;
                    finished_d     = '0;
                    winner_valid_d = 1'b0;
                end
            end
            RUN: begin
                timer_d    = timer_q + 32'd1;
                // Elimination beats a same-cycle finish for the same player.
                elim       = {N_PLAYERS{elim_armed}} & move_s & alive_q & ~finished_q;
                fin_new    = finish_s & alive_q & ~finished_q & ~elim;
                alive_d    = alive_q & ~elim;
                finished_d = finished_q | fin_new;
                if (!winner_valid_q && (fin_new != '0)) begin
                    winner_valid_d = 1'b1;
                    winner_d       = lowest_set(MAX_PLAYERS'(fin_new));
                end
                if (timer_q == TIME_LIMIT - 32'd1) begin
                    state_d = OVER;
                    alive_d = alive_d & finished_d;
                end else if ((~alive_q | finished_q) == '1) begin
                    state_d = OVER;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            timer_q        <= '0;
            alive_q        <= '0;
            finished_q     <= '0;
            winner_valid_q <= 1'b0;
            winner_q       <= '0;
            running_q      <= 1'b0;
            game_over_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            alive_q        <= alive_d;
            finished_q     <= finished_d;
            winner_valid_q <= winner_valid_d;
            winner_q       <= winner_d;
            running_q      <= (state_d == RUN);
            game_over_q    <= (state_d == OVER);
        end
    end

    assign alive        = alive_q;
    assign finished     = finished_q;
    assign running      = running_q;
    assign game_over    = game_over_q;
    assign winner_valid = winner_valid_q;
    assign winner       = winner_q;

endmodule
